// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator and DAC output stage.
//
// Divides the system clock down to the pixel rate, walks DrawX/DrawY across the full
// raster (visible area plus porches and sync) and registers the mapper's colour, blanked
// outside the visible area, together with HS/VS/BLANK so all of them reach the DAC aligned.
//
// Ports:
//   Clk, Reset_n            system clock, asynchronous active-low reset
//   Red_in/Green_in/Blue_in colour from the mapper for the current DrawX/DrawY
//   DrawX, DrawY            current raster coordinates (registered)
//   pixel_en                one-Clk pulse on the Clk edge where the raster advances
//   frame_start             one-Clk pulse after the raster wraps to (0,0)
//   VGA_CLK                 pixel clock to the DAC
//   VGA_HS, VGA_VS          active-low syncs
//   VGA_BLANK_N             low outside the visible area
//   VGA_SYNC_N              constant 0
//   VGA_R/G/B               registered, blank-gated colour
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned CLK_DIV   = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic [7:0] Red_in,
   input  logic [7:0] Green_in,
   input  logic [7:0] Blue_in,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       pixel_en,
   output logic       frame_start,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK_N,
   output logic       VGA_SYNC_N,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = $clog2(CLK_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] Y_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div_q, div_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic             vclk_q, vclk_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             blank_n_q, blank_n_d;
   logic             fs_q, fs_d;
   logic [7:0]       r_q, r_d;
   logic [7:0]       g_q, g_d;
   logic [7:0]       b_q, b_d;
   logic             vis;
   logic             line_end;

   always_comb begin
      pixel_en  = (div_q == DIV_LAST);
      div_d     = pixel_en ? '0 : div_q + 1'b1;
      // Registered from the pre-edge divider so VGA_CLK rises on the output-update edge.
      vclk_d    = (div_q >= DIV_HALF);
      vis       = (x_q < X_VIS) && (y_q < Y_VIS);
      line_end  = (x_q == X_LAST);

      x_d       = x_q;
      y_d       = y_q;
      hs_d      = hs_q;
      vs_d      = vs_q;
      blank_n_d = blank_n_q;
      r_d       = r_q;
      g_d       = g_q;
      b_d       = b_q;
      fs_d      = 1'b0;

      if (pixel_en) begin
         x_d = line_end ? '0 : x_q + 10'd1;
         if (line_end) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
         end
         // Output stage uses the pre-edge coordinates: one pixel of latency, all aligned.
         r_d       = vis ? Red_in   : 8'h00;
         g_d       = vis ? Green_in : 8'h00;
         b_d       = vis ? Blue_in  : 8'h00;
         blank_n_d = vis;
         hs_d      = ~((x_q >= HS_START) && (x_q < HS_END));
         vs_d      = ~((y_q >= VS_START) && (y_q < VS_END));
         fs_d      = line_end && (y_q == Y_LAST);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         vclk_q    <= 1'b0;
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         fs_q      <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
      end else begin
         div_q     <= div_d;
         x_q       <= x_d;
         y_q       <= y_d;
         vclk_q    <= vclk_d;
         hs_q      <= hs_d;
         vs_q      <= vs_d;
         blank_n_q <= blank_n_d;
         fs_q      <= fs_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
      end
   end

   assign DrawX       = x_q;
   assign DrawY       = y_q;
   assign frame_start = fs_q;
   assign VGA_CLK     = vclk_q;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK_N = blank_n_q;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen. Horizontal timing is the real 800-pixel line;
// the vertical raster is shortened so two whole frames fit in a short run.
module tb_vga_timing_gen;

   localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
   localparam int VV = 6, VF = 2, VSW = 2, VB = 2;
   localparam int CD = 2;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;
   localparam int FRAME_CLKS = HT * VT * CD;

   logic       Clk;
   logic       Reset_n;
   logic [7:0] Red_in, Green_in, Blue_in;
   logic [9:0] DrawX, DrawY;
   logic       pixel_en, frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic [7:0] VGA_R, VGA_G, VGA_B;

   vga_timing_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
      .CLK_DIV(CD)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .Red_in(Red_in), .Green_in(Green_in), .Blue_in(Blue_in),
      .DrawX(DrawX), .DrawY(DrawY), .pixel_en(pixel_en), .frame_start(frame_start),
      .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: clocks elapsed since reset release; everything derives from it.
   int         c = 0;
   logic [7:0] e_r = 0, e_g = 0, e_b = 0;
   logic       e_hs = 1, e_vs = 1, e_blank = 0, e_fs = 0, e_vclk = 0;
   int         last_px = 0, last_py = 0;
   logic       last_pix = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
         if (n_bad >= 50) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
         end
      end
   endtask

   function automatic logic [63:0] dut_state();
      return {13'd0, DrawX, DrawY, pixel_en, frame_start, VGA_CLK, VGA_HS, VGA_VS,
              VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B};
   endfunction

   function automatic logic [63:0] exp_state();
      logic [9:0] x, y;
      logic       pe;
      x  = 10'((c / CD) % HT);
      y  = 10'((c / CD / HT) % VT);
      pe = ((c % CD) == CD - 1);
      return {13'd0, x, y, pe, e_fs, e_vclk, e_hs, e_vs, e_blank, 1'b0, e_r, e_g, e_b};
   endfunction

   function automatic int cur_x();
      return (c / CD) % HT;
   endfunction

   function automatic int cur_y();
      return (c / CD / HT) % VT;
   endfunction

   // One Clk edge: advance the model, then compare the whole output state 1 time unit later.
   task automatic tick();
      int  div;
      bit  vis;
      @(posedge Clk);
      if (!Reset_n) begin
         c = 0;
         e_r = 0; e_g = 0; e_b = 0;
         e_hs = 1; e_vs = 1; e_blank = 0; e_fs = 0; e_vclk = 0;
         last_pix = 0;
      end else begin
         div      = c % CD;
         last_px  = cur_x();
         last_py  = cur_y();
         last_pix = (div == CD - 1);
         e_vclk   = (div >= CD / 2);
         e_fs     = 0;
         if (last_pix) begin
            vis     = (last_px < HV) && (last_py < VV);
            e_r     = vis ? Red_in : 8'h00;
            e_g     = vis ? Green_in : 8'h00;
            e_b     = vis ? Blue_in : 8'h00;
            e_blank = vis;
            e_hs    = !(last_px >= HV + HF && last_px < HV + HF + HSW);
            e_vs    = !(last_py >= VV + VF && last_py < VV + VF + VSW);
            e_fs    = (last_px == HT - 1) && (last_py == VT - 1);
         end
         c++;
      end
      #1;
      chk("state", dut_state(), exp_state());
   endtask

   task automatic set_rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      Red_in = r; Green_in = g; Blue_in = b;
   endtask

   typedef struct {
      logic [7:0] gr, gg, gb;   // glitch value on the non-advancing cycle
      logic [7:0] r, g, b;      // value present on the pixel_en edge
      logic [7:0] xr, xg, xb;   // expected DAC colour
   } vec_t;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      logic prev_vclk, prev_hs, prev_blank, prev_fs;
      int   hs_low, hs_fall_x, blank_fall_x, r_at_fall, guard;
      int   fs_cnt, fs_consec, last_fs_cyc, vs_low, max_y, wrap_seen, rows_pix, rows_bad;

      vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56};
      vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{8'hAA, 8'hBB, 8'hCC, 8'h01, 8'h80, 8'h7F, 8'h01, 8'h80, 8'h7F};
      vecs[3] = '{8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h3C, 8'h5A, 8'hA5, 8'h3C};
      vecs[5] = '{8'hC3, 8'h3C, 8'h99, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};

      // Reset held with non-zero colour.
      Reset_n = 1'b0;
      set_rgb(8'hFF, 8'hFF, 8'hFF);
      repeat (5) tick();
      chk("rst_hs", VGA_HS, 1);
      chk("rst_blank", VGA_BLANK_N, 0);
      chk("rst_r", VGA_R, 8'h00);

      // First pixel after release.
      Reset_n = 1'b1;
      set_rgb(8'hAA, 8'h55, 8'h0F);
      tick();
      chk("first_pe", pixel_en, 1);
      tick();
      chk("first_r", VGA_R, 8'hAA);
      chk("first_g", VGA_G, 8'h55);
      chk("first_b", VGA_B, 8'h0F);
      chk("first_blank", VGA_BLANK_N, 1);
      chk("first_x", DrawX, 1);

      // Table vectors: a glitch on the idle cycle must not reach the DAC.
      prev_vclk = VGA_CLK;
      for (int i = 0; i < 6; i++) begin
         set_rgb(vecs[i].gr, vecs[i].gg, vecs[i].gb);
         tick();
         chk("vclk_toggle", VGA_CLK, !prev_vclk);
         prev_vclk = VGA_CLK;
         set_rgb(vecs[i].r, vecs[i].g, vecs[i].b);
         tick();
         chk("vclk_toggle", VGA_CLK, !prev_vclk);
         prev_vclk = VGA_CLK;
         chk("vec_rgb", {VGA_R, VGA_G, VGA_B}, {vecs[i].xr, vecs[i].xg, vecs[i].xb});
      end
      chk("vec_x", DrawX, 7);

      // Run to DrawX=300, then reset asynchronously between clock edges.
      guard = 0;
      while (cur_x() != 300 && guard < 2000) begin
         set_rgb(8'($urandom), 8'($urandom), 8'($urandom));
         tick();
         guard++;
      end
      chk("reach_x300", cur_x(), 300);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("async_rst_x", DrawX, 0);
      chk("async_rst_state", dut_state(), {13'd0, 10'd0, 10'd0, 7'b0001100, 24'd0});
      tick();
      tick();
      Reset_n = 1'b1;

      // One full line from (0,0) with white input.
      set_rgb(8'hFF, 8'hFF, 8'hFF);
      prev_hs = 1; prev_blank = 0;
      hs_low = 0; hs_fall_x = -1; blank_fall_x = -1; r_at_fall = -1;
      for (int i = 0; i < HT * CD; i++) begin
         tick();
         if (!VGA_HS) hs_low++;
         if (prev_hs && !VGA_HS) hs_fall_x = last_px;
         if (prev_blank && !VGA_BLANK_N) begin
            blank_fall_x = last_px;
            r_at_fall    = int'(VGA_R);
         end
         prev_hs = VGA_HS; prev_blank = VGA_BLANK_N;
      end
      chk("hs_low_clks", hs_low, HSW * CD);
      chk("hs_fall_x", hs_fall_x, HV + HF);
      chk("blank_fall_x", blank_fall_x, HV);
      chk("blank_fall_r", r_at_fall, 0);

      // Two full frames of random colour; blanking rows driven white.
      prev_fs = 0; fs_cnt = 0; fs_consec = 0; last_fs_cyc = -1; vs_low = 0; max_y = 0;
      wrap_seen = 0; rows_pix = 0; rows_bad = 0;
      for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
         if (cur_y() >= VV) set_rgb(8'hFF, 8'hFF, 8'hFF);
         else set_rgb(8'($urandom), 8'($urandom), 8'($urandom));
         tick();
         if (frame_start) begin
            fs_cnt++;
            if (prev_fs) fs_consec++;
            if (last_fs_cyc >= 0) chk("fs_period", i - last_fs_cyc, FRAME_CLKS);
            last_fs_cyc = i;
         end
         prev_fs = frame_start;
         if (!VGA_VS) vs_low++;
         if (int'(DrawY) > max_y) max_y = int'(DrawY);
         if (last_pix && last_px == HT - 1 && last_py == 10) begin
            wrap_seen++;
            chk("wrap_x", DrawX, 0);
            chk("wrap_y", DrawY, 11);
            chk("wrap_fs", frame_start, 0);
         end
         if (last_pix && last_py >= VV) begin
            rows_pix++;
            if (VGA_BLANK_N || {VGA_R, VGA_G, VGA_B} != 24'd0) rows_bad++;
         end
      end
      chk("fs_count", fs_cnt, 2);
      chk("fs_width", fs_consec, 0);
      chk("vs_low_clks", vs_low, 2 * VSW * HT * CD);
      chk("max_drawy", max_y, VT - 1);
      chk("wrap_seen", wrap_seen, 2);
      chk("blank_rows_pix", rows_pix, 2 * (VT - VV) * HT);
      chk("blank_rows_bad", rows_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
